// File: rtl/upstream_mem_requester.sv
// Host-side request buffer that queues read/write requests and issues them
// one at a time to the downstream memory FSM over a four-phase req/ack handshake.
module upstream_mem_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_wr,
  output logic                       req,
  output logic                       memwr,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          wdata,
  input  logic                       ack,
  input  logic [DATA_W-1:0]          rdata,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state_r;
  logic [EW-1:0]  mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic           push_s;
  logic           pop_s;
  logic [EW-1:0]  head_s;

  assign in_ready = (count < DEPTH_C);
  assign push_s   = in_valid && in_ready;
  // A stale ack from the previous handshake blocks the next pop.
  assign pop_s    = (state_r == IDLE) && (count != {CW{1'b0}}) && !ack;
  assign head_s   = mem_r[rd_ptr_r];

  // Request FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_wr, in_addr, in_data};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake state machine with registered downstream and host-return outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      req         <= 1'b0;
      memwr       <= 1'b0;
      addr        <= {ADDR_W{1'b0}};
      wdata       <= {DATA_W{1'b0}};
      rd_data     <= {DATA_W{1'b0}};
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt_r   <= {TW{1'b0}};
    end else begin
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            memwr     <= head_s[EW-1];
            addr      <= head_s[EW-2 -: ADDR_W];
            wdata     <= head_s[DATA_W-1:0];
            req       <= 1'b1;
            tmo_cnt_r <= {TW{1'b0}};
            state_r   <= ISSUE;
          end else begin
            req     <= 1'b0;
            memwr   <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // ack takes priority over a timeout expiring on the same edge.
          if (ack) begin
            if (!memwr) begin
              rd_data  <= rdata;
              rd_valid <= 1'b1;
            end else begin
              rd_data <= rd_data;
            end
            req     <= 1'b0;
            memwr   <= 1'b0;
            state_r <= RELEASE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            timeout_err <= 1'b1;
            req         <= 1'b0;
            memwr       <= 1'b0;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            state_r   <= ISSUE;
          end
        end
        RELEASE: begin
          req   <= 1'b0;
          memwr <= 1'b0;
          if (!ack) begin
            state_r <= IDLE;
          end else begin
            state_r <= RELEASE;
          end
        end
        default: begin
          req     <= 1'b0;
          memwr   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upstream_mem_requester.sv
// Scoreboard bench: accepted requests are queued on push and compared against
// each downstream handshake; a small downstream model drives ack/rdata.
module tb_upstream_mem_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_wr;
  logic [7:0] in_addr, in_data;
  logic       req, memwr, ack;
  logic [7:0] addr, wdata, rdata, rd_data;
  logic       rd_valid, timeout_err;
  logic [2:0] count;

  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int rdv_n    = 0;
  int tmo_n    = 0;
  int both_n   = 0;

  upstream_mem_requester #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_wr(in_wr),
    .req(req), .memwr(memwr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .timeout_err(timeout_err),
    .count(count)
  );

  always #5 clk = ~clk;

  // Pulse monitor for rd_valid / timeout_err.
  always @(negedge clk) begin
    if (rd_valid) rdv_n <= rdv_n + 1;
    if (timeout_err) tmo_n <= tmo_n + 1;
    if (rd_valid && timeout_err) both_n <= both_n + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic exp_acc);
    in_valid = 1'b1;
    in_wr    = wr;
    in_addr  = a;
    in_data  = d;
    check_val("in_ready", in_ready, exp_acc);
    if (exp_acc) exp_q.push_back({wr, a, d});
    step();
    in_valid = 1'b0;
  endtask

  // Downstream model: ack two cycles after req rises, drop it one cycle after req falls.
  task automatic serve(input logic [7:0] rv);
    int n;
    int hi;
    logic [16:0] e;
    n  = 0;
    hi = 0;
    while (!req && n < 50) begin
      step();
      n++;
    end
    check_val("req_seen", req, 1);
    check_val("sb_nonempty", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
    while (req && hi < 20) begin
      check_val("addr", addr, e[15:8]);
      check_val("memwr", memwr, e[16]);
      if (e[16]) check_val("wdata", wdata, e[7:0]);
      check_val("rd_valid_during_req", rd_valid, 0);
      hi++;
      if (hi == 3) begin
        ack   = 1'b1;
        rdata = rv;
      end
      step();
    end
    check_val("req_hi_cycles", hi, 3);
    check_val("memwr_after", memwr, 0);
    check_val("rd_valid_pulse", rd_valid, !e[16]);
    if (!e[16]) check_val("rd_data", rd_data, rv);
    step();
    check_val("rd_valid_end", rd_valid, 0);
    ack   = 1'b0;
    rdata = 8'h00;
  endtask

  initial begin
    int hi;
    logic seen;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_wr    = 1'b0;
    in_addr  = 8'h00;
    in_data  = 8'h00;
    ack      = 1'b0;
    rdata    = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    check_val("rst_req", req, 0);
    check_val("rst_memwr", memwr, 0);
    check_val("rst_count", count, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_addr", addr, 0);
    check_val("rst_pulses", {rd_valid, timeout_err}, 0);

    // single write, then single read
    push(1'b1, 8'h12, 8'hA5, 1'b1);
    serve(8'h00);
    check_val("wr_count", count, 0);
    push(1'b0, 8'h34, 8'hFF, 1'b1);
    serve(8'h5C);
    check_val("rd_count", count, 0);

    // stale ack blocks issue so the FIFO fills; fifth push is dropped
    ack = 1'b1;
    step();
    push(1'b1, 8'h40, 8'h11, 1'b1);
    push(1'b0, 8'h41, 8'h22, 1'b1);
    push(1'b1, 8'h42, 8'h33, 1'b1);
    push(1'b0, 8'h43, 8'h44, 1'b1);
    push(1'b1, 8'h44, 8'h55, 1'b0);
    check_val("full_count", count, 4);
    check_val("full_req", req, 0);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) serve(8'h70 + 8'(i));
    check_val("stream_sb_empty", exp_q.size(), 0);
    check_val("stream_count", count, 0);

    // timeout: first entry never acked, second entry then issues normally
    push(1'b1, 8'h50, 8'hC3, 1'b1);
    push(1'b1, 8'h51, 8'h3C, 1'b1);
    hi = 0;
    while (req && hi < 40) begin
      hi++;
      step();
    end
    check_val("tmo_req_cycles", hi, 15);
    check_val("tmo_err_pulse", timeout_err, 1);
    check_val("tmo_rd_valid", rd_valid, 0);
    void'(exp_q.pop_front());
    step();
    check_val("tmo_err_end", timeout_err, 0);
    serve(8'h00);

    // asynchronous reset mid-ISSUE with two entries queued
    push(1'b1, 8'h60, 8'h01, 1'b1);
    push(1'b1, 8'h61, 8'h02, 1'b1);
    push(1'b0, 8'h62, 8'h03, 1'b1);
    check_val("pre_rst_count", count, 2);
    check_val("pre_rst_req", req, 1);
    #2 reset = 1'b1;
    #1;
    check_val("async_req", req, 0);
    check_val("async_memwr", memwr, 0);
    check_val("async_count", count, 0);
    step();
    reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req) seen = 1'b1;
      step();
    end
    check_val("post_rst_no_req", seen, 0);
    check_val("post_rst_count", count, 0);
    push(1'b0, 8'h99, 8'h00, 1'b1);
    serve(8'hE7);

    step();
    check_val("rd_valid_total", rdv_n, 4);
    check_val("timeout_total", tmo_n, 1);
    check_val("pulse_overlap", both_n, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
